// File: rtl/sopc_run_ctrl.sv
// Run controller for SOPC simulation and FPGA bring-up.
// Holds the core in reset for RST_CYCLES edges, lets it run, and watches for
// an end-of-test store to TOHOST_ADDR, a timeout, or a stalled pc. The outcome
// is latched and the core is held in reset until the next start pulse.
module sopc_run_ctrl #(
    parameter int unsigned       RST_CYCLES     = 10,
    parameter int unsigned       TIMEOUT_CYCLES = 500,
    parameter int unsigned       STALL_CYCLES   = 64,
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       CNT_W          = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_0FF0,
    parameter logic [DATA_W-1:0] PASS_VAL       = 32'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [ADDR_W-1:0] pc,
    output logic              core_rst,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              hung,
    output logic [DATA_W-1:0] result,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int unsigned       HOLD_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
    localparam int unsigned       STALL_W    = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'((STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]  TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit                STALL_EN   = (STALL_CYCLES > 0);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RUN,
        ST_END_OK,
        ST_END_TO,
        ST_END_HUNG
    } state_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               core_rst_q, core_rst_d;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               timeout_q, timeout_d;
    logic               hung_q, hung_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;

    logic tohost_hit;
    logic pc_same;
    logic restart;

    assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR);
    // cycle_count is zero only on the first RUN cycle, when pc_q holds nothing useful
    assign pc_same    = (cycle_count_q != '0) && (pc == pc_q);
    assign restart    = start && (state_q != ST_HOLD);

    // State and output registers; rst forces the reset-hold state immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            pc_q          <= '0;
            core_rst_q    <= 1'b1;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            hung_q        <= 1'b0;
            result_q      <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            pc_q          <= pc_d;
            core_rst_q    <= core_rst_d;
            running_q     <= running_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
            hung_q        <= hung_d;
            result_q      <= result_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    // Next-state and next-output logic; start outranks every RUN exit condition
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        pc_d          = pc_q;
        core_rst_d    = core_rst_q;
        running_d     = running_q;
        done_d        = done_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
        hung_d        = hung_q;
        result_d      = result_q;
        cycle_count_d = cycle_count_q;

        if (restart) begin
            state_d       = ST_HOLD;
            hold_cnt_d    = '0;
            stall_cnt_d   = '0;
            core_rst_d    = 1'b1;
            running_d     = 1'b0;
            done_d        = 1'b0;
            pass_d        = 1'b0;
            timeout_d     = 1'b0;
            hung_d        = 1'b0;
            result_d      = '0;
            cycle_count_d = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    core_rst_d = 1'b1;
                    if (start) begin
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d       = ST_RUN;
                        hold_cnt_d    = '0;
                        stall_cnt_d   = '0;
                        core_rst_d    = 1'b0;
                        running_d     = 1'b1;
                        cycle_count_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                    pc_d          = pc;
                    if (STALL_EN) begin
                        stall_cnt_d = pc_same ? stall_cnt_q + STALL_W'(1) : '0;
                    end
                    if (tohost_hit) begin
                        state_d    = ST_END_OK;
                        result_d   = mem_wdata;
                        pass_d     = (mem_wdata == PASS_VAL);
                        done_d     = 1'b1;
                        running_d  = 1'b0;
                        core_rst_d = 1'b1;
                    end else if (cycle_count_q == TO_LAST) begin
                        state_d    = ST_END_TO;
                        timeout_d  = 1'b1;
                        done_d     = 1'b1;
                        running_d  = 1'b0;
                        core_rst_d = 1'b1;
                    end else if (STALL_EN && pc_same && (stall_cnt_q == STALL_LAST)) begin
                        state_d    = ST_END_HUNG;
                        hung_d     = 1'b1;
                        done_d     = 1'b1;
                        running_d  = 1'b0;
                        core_rst_d = 1'b1;
                    end
                end
                ST_END_OK, ST_END_TO, ST_END_HUNG: begin
                    core_rst_d = 1'b1;
                end
                default: begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                    core_rst_d = 1'b1;
                    running_d  = 1'b0;
                end
            endcase
        end
    end

    assign core_rst    = core_rst_q;
    assign running     = running_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign hung        = hung_q;
    assign result      = result_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Bench for sopc_run_ctrl: two instances share all stimulus, one with stall
// detection (64) and one with it disabled. Each run's outcome is predicted from
// the per-cycle stimulus tables by a simple rule-based model.
module tb_sopc_run_ctrl;

    localparam int          RSTC    = 10;
    localparam int          TO      = 500;
    localparam int          STALL_A = 64;
    localparam logic [31:0] TOHOST  = 32'h0000_0FF0;
    localparam logic [31:0] PASSV   = 32'd1;
    localparam int          K_OK    = 0;
    localparam int          K_TO    = 1;
    localparam int          K_HUNG  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] pc = '0;

    logic        a_core_rst, a_running, a_done, a_pass, a_timeout, a_hung;
    logic [31:0] a_result, a_cycle_count;
    logic        b_core_rst, b_running, b_done, b_pass, b_timeout, b_hung;
    logic [31:0] b_result, b_cycle_count;

    // Per-RUN-cycle stimulus tables
    logic        we_t   [TO];
    logic [31:0] addr_t [TO];
    logic [31:0] data_t [TO];
    logic [31:0] pc_t   [TO];

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    sopc_run_ctrl #(
        .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TO), .STALL_CYCLES(STALL_A),
        .ADDR_W(32), .DATA_W(32), .CNT_W(32),
        .TOHOST_ADDR(TOHOST), .PASS_VAL(PASSV)
    ) u_a (
        .clk(clk), .rst(rst_n), .start(start), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pc(pc),
        .core_rst(a_core_rst), .running(a_running), .done(a_done), .pass(a_pass),
        .timeout(a_timeout), .hung(a_hung), .result(a_result), .cycle_count(a_cycle_count)
    );

    sopc_run_ctrl #(
        .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TO), .STALL_CYCLES(0),
        .ADDR_W(32), .DATA_W(32), .CNT_W(32),
        .TOHOST_ADDR(TOHOST), .PASS_VAL(PASSV)
    ) u_b (
        .clk(clk), .rst(rst_n), .start(start), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pc(pc),
        .core_rst(b_core_rst), .running(b_running), .done(b_done), .pass(b_pass),
        .timeout(b_timeout), .hung(b_hung), .result(b_result), .cycle_count(b_cycle_count)
    );

    // Outcome of one run: first cycle with a tohost store wins, then the
    // timeout cycle, then the first cycle whose unchanged-pc streak reaches stall.
    function automatic void predict(input int stall, output int kind, output int cnt,
                                    output logic [31:0] res);
        int streak;
        streak = 0;
        kind   = K_TO;
        cnt    = TO;
        res    = '0;
        for (int c = 0; c < TO; c++) begin
            if (c > 0 && pc_t[c] == pc_t[c-1]) streak++;
            else streak = 0;
            if (we_t[c] && addr_t[c] == TOHOST) begin
                kind = K_OK; cnt = c + 1; res = data_t[c]; return;
            end
            if (c == TO - 1) begin
                kind = K_TO; cnt = TO; return;
            end
            if (stall > 0 && streak >= stall) begin
                kind = K_HUNG; cnt = c + 1; return;
            end
        end
    endfunction

    task automatic gen_base();
        for (int c = 0; c < TO; c++) begin
            we_t[c]   = 1'b0;
            addr_t[c] = '0;
            data_t[c] = '0;
            pc_t[c]   = 32'h0000_0100 + 32'(c * 4);
        end
    endtask

    task automatic idle_bus();
        mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    endtask

    // Counts rising edges until core_rst drops (bounded)
    task automatic wait_hold(output int edges);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (a_core_rst && edges < 100);
    endtask

    // Restart both instances from any state and return in the first RUN cycle
    task automatic begin_run();
        int e;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_hold(e);
        vectors++;
        if (e !== RSTC) begin
            fails++;
            $display("FAIL restart_len: core_rst high for %0d edges, expected %0d", e, RSTC);
        end
    endtask

    // Drives the stimulus tables through a run and checks both instances
    task automatic run_and_check(input string tag);
        int ka, kb, ca, cb, ea, eb;
        logic [31:0] ra, rb;
        logic [5:0]  fa, fb;
        predict(STALL_A, ka, ca, ra);
        predict(0, kb, cb, rb);
        for (int i = 0; i <= TO; i++) begin
            ea = (i < ca) ? i : ca;
            eb = (i < cb) ? i : cb;
            vectors++;
            if (a_cycle_count !== 32'(ea) || a_done !== (i >= ca)) begin
                fails++;
                $display("FAIL %s A step %0d: cycle_count=%0d done=%b, expected %0d %b",
                         tag, i, a_cycle_count, a_done, ea, (i >= ca));
            end
            vectors++;
            if (b_cycle_count !== 32'(eb) || b_done !== (i >= cb)) begin
                fails++;
                $display("FAIL %s B step %0d: cycle_count=%0d done=%b, expected %0d %b",
                         tag, i, b_cycle_count, b_done, eb, (i >= cb));
            end
            if (i < TO) begin
                mem_we = we_t[i]; mem_addr = addr_t[i]; mem_wdata = data_t[i]; pc = pc_t[i];
                @(posedge clk); #1;
            end
        end
        idle_bus();
        // {core_rst, running, done, pass, timeout, hung}
        fa = {3'b101, (ka == K_OK && ra == PASSV), (ka == K_TO), (ka == K_HUNG)};
        fb = {3'b101, (kb == K_OK && rb == PASSV), (kb == K_TO), (kb == K_HUNG)};
        vectors++;
        if ({a_core_rst, a_running, a_done, a_pass, a_timeout, a_hung} !== fa) begin
            fails++;
            $display("FAIL %s A flags: got %b expected %b", tag,
                     {a_core_rst, a_running, a_done, a_pass, a_timeout, a_hung}, fa);
        end
        vectors++;
        if (a_result !== ((ka == K_OK) ? ra : 32'h0)) begin
            fails++;
            $display("FAIL %s A result: got %h expected %h", tag, a_result, (ka == K_OK) ? ra : 32'h0);
        end
        vectors++;
        if ({b_core_rst, b_running, b_done, b_pass, b_timeout, b_hung} !== fb) begin
            fails++;
            $display("FAIL %s B flags: got %b expected %b", tag,
                     {b_core_rst, b_running, b_done, b_pass, b_timeout, b_hung}, fb);
        end
        vectors++;
        if (b_result !== ((kb == K_OK) ? rb : 32'h0)) begin
            fails++;
            $display("FAIL %s B result: got %h expected %h", tag, b_result, (kb == K_OK) ? rb : 32'h0);
        end
    endtask

    task automatic test_reset();
        int e;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if ({a_core_rst, a_running, a_done, a_pass, a_timeout, a_hung, a_result, a_cycle_count}
            !== {6'b100000, 64'h0}) begin
            fails++;
            $display("FAIL reset_values: flags=%b result=%h count=%0d, expected 100000 0 0",
                     {a_core_rst, a_running, a_done, a_pass, a_timeout, a_hung}, a_result, a_cycle_count);
        end
        @(negedge clk); rst_n = 1'b1;
        wait_hold(e);
        vectors++;
        if (e !== RSTC) begin
            fails++;
            $display("FAIL reset_hold_len: core_rst high for %0d edges, expected %0d", e, RSTC);
        end
        vectors++;
        if ({a_core_rst, a_running, a_done, b_running, a_cycle_count} !== {4'b0101, 32'h0}) begin
            fails++;
            $display("FAIL first_run_cycle: core_rst/running/done/b_running=%b count=%0d, expected 0101 0",
                     {a_core_rst, a_running, a_done, b_running}, a_cycle_count);
        end
    endtask

    task automatic test_pass();
        begin_run();
        gen_base();
        we_t[10] = 1'b1; addr_t[10] = 32'h0000_0FF4; data_t[10] = 32'd1;
        we_t[37] = 1'b1; addr_t[37] = TOHOST;        data_t[37] = 32'd1;
        run_and_check("pass");
    endtask

    task automatic test_restart();
        int e;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        vectors++;
        if ({a_core_rst, a_running, a_done, a_pass, a_timeout, a_hung, a_result, a_cycle_count}
            !== {6'b100000, 64'h0}) begin
            fails++;
            $display("FAIL restart_clear: flags=%b result=%h count=%0d, expected 100000 0 0",
                     {a_core_rst, a_running, a_done, a_pass, a_timeout, a_hung}, a_result, a_cycle_count);
        end
        // start again partway through the hold to restart its count
        repeat (4) @(posedge clk);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_hold(e);
        vectors++;
        if (e !== RSTC) begin
            fails++;
            $display("FAIL hold_restart_len: core_rst high for %0d edges, expected %0d", e, RSTC);
        end
        vectors++;
        if ({a_running, b_running, a_cycle_count} !== {2'b11, 32'h0}) begin
            fails++;
            $display("FAIL restart_run: running a/b=%b count=%0d, expected 11 0",
                     {a_running, b_running}, a_cycle_count);
        end
    endtask

    task automatic test_fail_value();
        int at;
        begin_run();
        gen_base();
        at = int'($urandom_range(20, 300));
        we_t[5]  = 1'b1; addr_t[5]  = 32'h0000_0FF4; data_t[5]  = 32'd1;
        we_t[at] = 1'b1; addr_t[at] = TOHOST;        data_t[at] = 32'h0000_DEAD;
        run_and_check("fail_value");
    endtask

    task automatic test_timeout();
        begin_run();
        gen_base();
        // near-miss addresses differing from tohost in one bit anywhere in the word
        for (int c = 0; c < TO; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                we_t[c]   = 1'b1;
                addr_t[c] = TOHOST ^ (32'h1 << $urandom_range(0, 31));
                data_t[c] = PASSV;
            end
        end
        run_and_check("timeout");
    endtask

    task automatic test_timeout_tie();
        begin_run();
        gen_base();
        we_t[TO-1] = 1'b1; addr_t[TO-1] = TOHOST; data_t[TO-1] = PASSV;
        run_and_check("timeout_tie");
    endtask

    task automatic test_hung();
        begin_run();
        gen_base();
        for (int c = 0; c < TO; c++) pc_t[c] = 32'h0000_0040;
        run_and_check("hung");
    endtask

    task automatic test_start_mid_run();
        int e;
        begin_run();
        for (int i = 0; i < 15; i++) begin
            pc = 32'h0000_0200 + 32'(i * 4);
            @(posedge clk); #1;
        end
        start = 1'b1; mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = PASSV;
        @(posedge clk); #1;
        start = 1'b0; idle_bus();
        vectors++;
        if ({a_core_rst, a_running, a_done, a_pass, a_timeout, a_hung, a_result, a_cycle_count}
            !== {6'b100000, 64'h0}) begin
            fails++;
            $display("FAIL start_over_hit: flags=%b result=%h count=%0d, expected 100000 0 0",
                     {a_core_rst, a_running, a_done, a_pass, a_timeout, a_hung}, a_result, a_cycle_count);
        end
        wait_hold(e);
        vectors++;
        if (e !== RSTC) begin
            fails++;
            $display("FAIL start_mid_run_len: core_rst high for %0d edges, expected %0d", e, RSTC);
        end
    endtask

    task automatic test_random(input int n);
        int hs, hl, hit_at;
        for (int s = 0; s < n; s++) begin
            begin_run();
            gen_base();
            hs     = int'($urandom_range(0, 450));
            hl     = int'($urandom_range(30, 90));
            hit_at = int'($urandom_range(0, 700));
            pc_t[0] = $urandom;
            for (int c = 1; c < TO; c++) begin
                if ((c >= hs && c < hs + hl) || $urandom_range(0, 4) == 0) pc_t[c] = pc_t[c-1];
                else pc_t[c] = pc_t[c-1] + 32'd4;
            end
            for (int c = 0; c < TO; c++) begin
                if ($urandom_range(0, 19) == 0) begin
                    we_t[c]   = 1'b1;
                    addr_t[c] = TOHOST ^ (32'h1 << $urandom_range(0, 31));
                    data_t[c] = $urandom;
                end
            end
            if (hit_at < TO) begin
                we_t[hit_at]   = 1'b1;
                addr_t[hit_at] = TOHOST;
                data_t[hit_at] = ($urandom_range(0, 1) == 1) ? PASSV : $urandom;
            end
            run_and_check($sformatf("random%0d", s));
        end
    endtask

    task automatic test_async_reset();
        int e;
        begin_run();
        for (int i = 0; i < 20; i++) begin
            pc = 32'h0000_0300 + 32'(i * 4);
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({a_core_rst, a_running, a_done, a_pass, a_timeout, a_hung, a_result, a_cycle_count}
            !== {6'b100000, 64'h0}) begin
            fails++;
            $display("FAIL async_reset: flags=%b result=%h count=%0d, expected 100000 0 0",
                     {a_core_rst, a_running, a_done, a_pass, a_timeout, a_hung}, a_result, a_cycle_count);
        end
        vectors++;
        if ({b_core_rst, b_running, b_cycle_count} !== {2'b10, 32'h0}) begin
            fails++;
            $display("FAIL async_reset_b: core_rst/running=%b count=%0d, expected 10 0",
                     {b_core_rst, b_running}, b_cycle_count);
        end
        @(negedge clk); rst_n = 1'b1;
        wait_hold(e);
        vectors++;
        if (e !== RSTC || a_done !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_rearm: hold=%0d done=%b, expected %0d 0", e, a_done, RSTC);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_restart();
        test_fail_value();
        test_timeout();
        test_timeout_tie();
        test_hung();
        test_start_mid_run();
        test_random(8);
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
